// File: rtl/rf_pkg.sv
// Shared register-file sizing defaults and the address-width helper,
// also used by the ALU and control blocks.
package rf_pkg;

    localparam int RF_WIDTH   = 16;
    localparam int RF_NUM_REG = 4;

    function automatic int addr_w(input int num_reg);
        return $clog2(num_reg);
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, a live count of busy
// registers, and the busy read muxes with same-cycle retire visibility.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter  int NUM_REG = RF_NUM_REG,
    localparam int ADDR_W  = addr_w(NUM_REG)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              claim_en,
    input  logic [ADDR_W-1:0] claim_addr,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic              rd_busy1,
    output logic              rd_busy2,
    output logic [ADDR_W:0]   pend_cnt
);

    logic [NUM_REG-1:0] busy;
    logic [NUM_REG-1:0] busy_nxt;
    logic               same_addr;
    logic               inc;
    logic               dec;

    always_comb begin
        same_addr = wr_en && claim_en && (wr_addr == claim_addr);
        inc       = claim_en && !busy[claim_addr];
        dec       = wr_en && busy[wr_addr] && !same_addr;
        busy_nxt  = busy;
        if (wr_en)
            busy_nxt[wr_addr] = 1'b0;
        // Claim is applied last so a colliding write leaves the new writer pending.
        if (claim_en)
            busy_nxt[claim_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy     <= '0;
            pend_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            pend_cnt <= pend_cnt + {{ADDR_W{1'b0}}, inc} - {{ADDR_W{1'b0}}, dec};
        end
    end

    assign rd_busy1 = busy[rd_addr1] & ~(wr_en && (wr_addr == rd_addr1));
    assign rd_busy2 = busy[rd_addr2] & ~(wr_en && (wr_addr == rd_addr2));

endmodule

// File: rtl/reg_file_sb.sv
// Two-read/one-write register file with write-first bypass and a pending-write
// scoreboard used by decode for RAW hazard detection.
module reg_file_sb
    import rf_pkg::*;
#(
    parameter  int WIDTH    = RF_WIDTH,
    parameter  int NUM_REG  = RF_NUM_REG,
    parameter  bit ZERO_REG = 1'b0,
    localparam int ADDR_W   = addr_w(NUM_REG)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [WIDTH-1:0]  rd_data1,
    output logic [WIDTH-1:0]  rd_data2,
    output logic              rd_busy1,
    output logic              rd_busy2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              claim_en,
    input  logic [ADDR_W-1:0] claim_addr,
    output logic [ADDR_W:0]   pend_cnt
);

    logic [WIDTH-1:0] regs [NUM_REG];
    logic             wr_eff;
    logic             claim_eff;

    // With ZERO_REG, register 0 is hardwired: writes and claims to it vanish here,
    // so neither the array, the bypass nor the scoreboard ever sees them.
    assign wr_eff    = wr_en && reset_n && !(ZERO_REG && (wr_addr == '0));
    assign claim_eff = claim_en && reset_n && !(ZERO_REG && (claim_addr == '0));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REG; i++)
                regs[i] <= '0;
        end else if (wr_eff) begin
            regs[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data1 = (wr_eff && (wr_addr == rd_addr1)) ? wr_data : regs[rd_addr1];
        rd_data2 = (wr_eff && (wr_addr == rd_addr2)) ? wr_data : regs[rd_addr2];
        if (ZERO_REG && (rd_addr1 == '0))
            rd_data1 = '0;
        if (ZERO_REG && (rd_addr2 == '0))
            rd_data2 = '0;
    end

    rf_scoreboard #(
        .NUM_REG (NUM_REG)
    ) u_scoreboard (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_en      (wr_eff),
        .wr_addr    (wr_addr),
        .claim_en   (claim_eff),
        .claim_addr (claim_addr),
        .rd_addr1   (rd_addr1),
        .rd_addr2   (rd_addr2),
        .rd_busy1   (rd_busy1),
        .rd_busy2   (rd_busy2),
        .pend_cnt   (pend_cnt)
    );

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: stimulus queues expected outputs, a monitor
// on the falling edge pops and compares them against two instances (ZERO_REG 0/1).
module tb_reg_file_sb;

    localparam int W  = 16;
    localparam int NR = 4;
    localparam int AW = 2;

    typedef enum int {D1, D2, B1, B2, PC, ZD1, ZB1, ZPC} sig_e;

    typedef struct {
        string       name;
        sig_e        sig;
        logic [15:0] exp;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [AW-1:0] rd_addr1, rd_addr2, wr_addr, claim_addr;
    logic [W-1:0]  wr_data;
    logic          wr_en, claim_en;

    logic [W-1:0]  rd_data1, rd_data2, z_rd_data1, z_rd_data2;
    logic          rd_busy1, rd_busy2, z_rd_busy1, z_rd_busy2;
    logic [AW:0]   pend_cnt, z_pend_cnt;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    reg_file_sb dut (
        .clk(clk), .reset_n(reset_n),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .claim_en(claim_en), .claim_addr(claim_addr),
        .pend_cnt(pend_cnt)
    );

    reg_file_sb #(.ZERO_REG(1'b1)) dutz (
        .clk(clk), .reset_n(reset_n),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(z_rd_data1), .rd_data2(z_rd_data2),
        .rd_busy1(z_rd_busy1), .rd_busy2(z_rd_busy2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .claim_en(claim_en), .claim_addr(claim_addr),
        .pend_cnt(z_pend_cnt)
    );

    task automatic expect_out(input string name, input sig_e sig, input logic [15:0] exp);
        exp_t e;
        e.name = name;
        e.sig  = sig;
        e.exp  = exp;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en    = 1'b0;
        claim_en = 1'b0;
    endtask

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t        e;
            logic [15:0] act;
            e = q.pop_front();
            case (e.sig)
                D1:      act = rd_data1;
                D2:      act = rd_data2;
                B1:      act = {15'd0, rd_busy1};
                B2:      act = {15'd0, rd_busy2};
                PC:      act = {13'd0, pend_cnt};
                ZD1:     act = z_rd_data1;
                ZB1:     act = {15'd0, z_rd_busy1};
                default: act = {13'd0, z_pend_cnt};
            endcase
            n_tests++;
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int claim_seq [5] = '{0, 1, 1, 2, 3};
        int claim_pc  [5] = '{1, 2, 2, 3, 4};

        reset_n = 1'b0;
        rd_addr1 = '0; rd_addr2 = 2'd1;
        wr_addr = '0; wr_data = '0; claim_addr = '0;
        idle();
        step();
        expect_out("rst_pc", PC, 0);
        expect_out("rst_d1", D1, 0);
        expect_out("rst_b1", B1, 0);
        expect_out("rst_d2", D2, 0);
        step();
        reset_n = 1'b1;

        // bypass
        step();
        wr_en = 1'b1; wr_addr = 2'd2; wr_data = 16'hBEEF; rd_addr1 = 2'd2;
        expect_out("byp_same", D1, 16'hBEEF);
        step();
        idle();
        expect_out("byp_array", D1, 16'hBEEF);
        expect_out("byp_busy", B1, 0);

        // claim / retire
        step();
        claim_en = 1'b1; claim_addr = 2'd1; rd_addr1 = 2'd1;
        expect_out("claim_not_yet", B1, 0);
        step();
        idle();
        expect_out("claim_busy", B1, 1);
        expect_out("claim_pc", PC, 1);
        step();
        wr_en = 1'b1; wr_addr = 2'd1; wr_data = 16'h1234;
        expect_out("retire_busy_same", B1, 0);
        expect_out("retire_data_same", D1, 16'h1234);
        expect_out("retire_pc_before", PC, 1);
        step();
        idle();
        expect_out("retire_pc_after", PC, 0);
        expect_out("retire_data", D1, 16'h1234);

        // collision on r3
        step();
        claim_en = 1'b1; claim_addr = 2'd3; rd_addr2 = 2'd3;
        step();
        idle();
        expect_out("col_pre_pc", PC, 1);
        expect_out("col_pre_b2", B2, 1);
        step();
        wr_en = 1'b1; wr_addr = 2'd3; wr_data = 16'h00AA;
        claim_en = 1'b1; claim_addr = 2'd3;
        expect_out("col_byp_d2", D2, 16'h00AA);
        expect_out("col_byp_b2", B2, 0);
        step();
        idle();
        expect_out("col_d2", D2, 16'h00AA);
        expect_out("col_b2", B2, 1);
        expect_out("col_pc", PC, 1);
        step();
        wr_en = 1'b1; wr_addr = 2'd3; wr_data = 16'h00AA;
        step();
        idle();
        expect_out("col_retire_pc", PC, 0);

        // register 0 with and without ZERO_REG
        step();
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 16'hFFFF;
        claim_en = 1'b1; claim_addr = 2'd0; rd_addr1 = 2'd0;
        expect_out("r0_byp", D1, 16'hFFFF);
        expect_out("z_r0_byp", ZD1, 0);
        expect_out("z_r0_byp_busy", ZB1, 0);
        step();
        idle();
        expect_out("r0_data", D1, 16'hFFFF);
        expect_out("r0_busy", B1, 1);
        expect_out("r0_pc", PC, 1);
        expect_out("z_r0_data", ZD1, 0);
        expect_out("z_r0_busy", ZB1, 0);
        expect_out("z_r0_pc", ZPC, 0);
        step();
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 16'hFFFF;
        step();
        idle();
        expect_out("r0_retire_pc", PC, 0);

        // fill then drain in reverse
        foreach (claim_seq[i]) begin
            step();
            claim_en = 1'b1; claim_addr = AW'(claim_seq[i]);
            step();
            idle();
            expect_out($sformatf("fill_pc_%0d", i), PC, 16'(claim_pc[i]));
        end
        for (int r = NR - 1; r >= 0; r--) begin
            step();
            wr_en = 1'b1; wr_addr = AW'(r); wr_data = 16'h1000 + 16'(r);
            step();
            idle();
            expect_out($sformatf("drain_pc_%0d", r), PC, 16'(r));
        end

        // async reset mid-operation
        step();
        claim_en = 1'b1; claim_addr = 2'd2; rd_addr1 = 2'd2;
        step();
        idle();
        expect_out("pre_rst_d1", D1, 16'h1002);
        expect_out("pre_rst_b1", B1, 1);
        expect_out("pre_rst_pc", PC, 1);
        step();
        reset_n = 1'b0;
        claim_en = 1'b1; claim_addr = 2'd1;
        expect_out("mid_rst_d1", D1, 0);
        expect_out("mid_rst_b1", B1, 0);
        expect_out("mid_rst_pc", PC, 0);
        #1;
        n_tests++;
        if (pend_cnt !== 3'd0) begin
            n_fail++;
            $display("FAIL async_rst_pc: got %h expected 0", pend_cnt);
        end
        n_tests++;
        if (rd_busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL async_rst_b1: got %b expected 0", rd_busy1);
        end
        n_tests++;
        if (rd_data1 !== 16'h0000) begin
            n_fail++;
            $display("FAIL async_rst_d1: got %h expected 0", rd_data1);
        end
        n_tests++;
        if (z_pend_cnt !== 3'd0) begin
            n_fail++;
            $display("FAIL async_rst_zpc: got %h expected 0", z_pend_cnt);
        end
        step();
        idle();
        reset_n = 1'b1;
        rd_addr1 = 2'd1;
        expect_out("post_rst_b1", B1, 0);
        expect_out("post_rst_pc", PC, 0);

        step();
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL queue not drained: %0d left", q.size());
        end
        if (n_tests < 12) begin
            n_fail++;
            $display("FAIL too few checks: %0d", n_tests);
        end
        if (n_fail == 0)
            $display("PASS");
        else
            $display("FAIL %0d checks failed", n_fail);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
